// File: rtl/ddr_if_pkg.sv
// Shared constants and helpers for the DDR port arbiter and its upstream channels.
// onehot() covers up to MAX_CH channels; callers keep only the low bits they use.

package ddr_if_pkg;

    localparam int unsigned DDR_DATA_W = 512;
    localparam int unsigned DDR_ADDR_W = 32;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned MAX_CH = 8;

    function automatic logic [MAX_CH-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// Synchronous tag FIFO with first-word-fall-through head.
// Pushes while full and pops while empty are ignored.

module ddr_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Merges NUM_CH upstream DDR request channels onto one downstream port and routes
// in-order read data back to the issuing channel via a tag FIFO.

module ddr_port_arbiter
    import ddr_if_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DATA_W          = DDR_DATA_W,
    parameter int unsigned ADDR_W          = DDR_ADDR_W,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned ARB_MODE        = ARB_RR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 ch_DDR_en,
    input  logic [NUM_CH-1:0]                 ch_DDR_en_wr,
    input  logic [NUM_CH*ADDR_W-1:0]          ch_DDR_adr,
    input  logic [NUM_CH*DATA_W-1:0]          ch_DDR_in,
    output logic [NUM_CH-1:0]                 ch_DDR_ready,
    output logic [NUM_CH-1:0]                 ch_DDR_valid,
    output logic [DATA_W-1:0]                 ch_DDR_out,
    output logic                              DDR_en,
    output logic                              DDR_en_wr,
    output logic [ADDR_W-1:0]                 DDR_adr,
    output logic [DATA_W-1:0]                 DDR_in,
    input  logic                              DDR_rdy,
    input  logic                              DDR_valid,
    input  logic [DATA_W-1:0]                 DDR_out,
    output logic [$clog2(MAX_OUTSTANDING):0]  rd_outstanding,
    output logic                              err_orphan
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic              ddr_en_q;
    logic              ddr_en_wr_q;
    logic [ADDR_W-1:0] ddr_adr_q;
    logic [DATA_W-1:0] ddr_in_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [NUM_CH-1:0] rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_orphan_q;

    logic              oreg_free;
    logic [NUM_CH-1:0] eligible;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    int unsigned       scan_idx;

    logic              tag_push;
    logic              tag_pop;
    logic [CH_W-1:0]   tag_head;
    logic [CNT_W-1:0]  tag_count;
    logic              tag_empty;

    assign oreg_free = !ddr_en_q || DDR_rdy;

    // Read eligibility uses the pre-pop count so a same-cycle pop cannot free a slot.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            eligible[i] = ch_DDR_en[i] && (ch_DDR_en_wr[i] || (tag_count < MAX_CNT));
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        if (rst_n && oreg_free) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                scan_idx = (ARB_MODE == ARB_FIXED) ? k : 32'(rr_ptr_q) + k;
                if (scan_idx >= NUM_CH) begin
                    scan_idx = scan_idx - NUM_CH;
                end
                if (!grant_valid && eligible[CH_W'(scan_idx)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(scan_idx);
                end
            end
        end
    end

    assign ch_DDR_ready = grant_valid ? NUM_CH'(onehot(3'(grant_idx))) : '0;

    assign tag_push = grant_valid && !ch_DDR_en_wr[grant_idx];
    assign tag_pop  = DDR_valid && !tag_empty;

    ddr_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push),
        .push_data (grant_idx),
        .pop       (tag_pop),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty)
    );

    // Output register: reload on grant, otherwise drain when downstream accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ddr_en_q    <= 1'b0;
            ddr_en_wr_q <= 1'b0;
            ddr_adr_q   <= '0;
            ddr_in_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (grant_valid) begin
                ddr_en_q    <= 1'b1;
                ddr_en_wr_q <= ch_DDR_en_wr[grant_idx];
                ddr_adr_q   <= ch_DDR_adr[grant_idx*ADDR_W +: ADDR_W];
                ddr_in_q    <= ch_DDR_in[grant_idx*DATA_W +: DATA_W];
            end else if (DDR_rdy) begin
                ddr_en_q <= 1'b0;
            end
            if (ARB_MODE == ARB_RR && grant_valid) begin
                rr_ptr_q <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rsp_valid_q <= tag_pop ? NUM_CH'(onehot(3'(tag_head))) : '0;
            if (tag_pop) begin
                rsp_data_q <= DDR_out;
            end
            if (DDR_valid && tag_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    assign DDR_en         = ddr_en_q;
    assign DDR_en_wr      = ddr_en_wr_q;
    assign DDR_adr        = ddr_adr_q;
    assign DDR_in         = ddr_in_q;
    assign ch_DDR_valid   = rsp_valid_q;
    assign ch_DDR_out     = rsp_data_q;
    assign rd_outstanding = tag_count;
    assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: a round-robin and a fixed-priority instance
// share stimulus; a negedge monitor checks grants, downstream requests and responses.

module tb_ddr_port_arbiter;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 32;
    localparam int MAX_OUT = 8;
    localparam int CNT_W   = 4;

    typedef struct {
        int                ch;
        logic              wr;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } dreq_t;

    typedef struct packed {
        logic [NUM_CH-1:0] oh;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH-1:0]        ch_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_adr;
    logic [NUM_CH*DATA_W-1:0] ch_in;
    logic                     ddr_rdy;
    logic                     ddr_valid;
    logic [DATA_W-1:0]        ddr_out;

    logic [NUM_CH-1:0] rdy_rr, val_rr, rdy_fx, val_fx;
    logic [DATA_W-1:0] out_rr, out_fx, in_rr, in_fx;
    logic              en_rr, wr_rr, en_fx, wr_fx, orph_rr, orph_fx;
    logic [ADDR_W-1:0] adr_rr, adr_fx;
    logic [CNT_W-1:0]  cnt_rr, cnt_fx;

    int errors = 0;
    int checks = 0;

    req_t              pend_q[$];
    logic [NUM_CH-1:0] exp_grant_q[$];
    dreq_t             exp_req_q[$];
    rsp_t              exp_rsp_q[$];
    logic [NUM_CH-1:0] acc;
    logic              drive_fix;

    logic [NUM_CH-1:0] mon_r;
    logic              mon_en;
    dreq_t             mon_act;
    dreq_t             mon_req;
    rsp_t              mon_rsp;

    ddr_port_arbiter #(
        .NUM_CH (NUM_CH), .DATA_W (DATA_W), .ADDR_W (ADDR_W),
        .MAX_OUTSTANDING (MAX_OUT), .ARB_MODE (0)
    ) u_rr (
        .clk (clk), .rst_n (rst_n), .ch_DDR_en (ch_en), .ch_DDR_en_wr (ch_wr),
        .ch_DDR_adr (ch_adr), .ch_DDR_in (ch_in), .ch_DDR_ready (rdy_rr),
        .ch_DDR_valid (val_rr), .ch_DDR_out (out_rr), .DDR_en (en_rr),
        .DDR_en_wr (wr_rr), .DDR_adr (adr_rr), .DDR_in (in_rr), .DDR_rdy (ddr_rdy),
        .DDR_valid (ddr_valid), .DDR_out (ddr_out), .rd_outstanding (cnt_rr),
        .err_orphan (orph_rr)
    );

    ddr_port_arbiter #(
        .NUM_CH (NUM_CH), .DATA_W (DATA_W), .ADDR_W (ADDR_W),
        .MAX_OUTSTANDING (MAX_OUT), .ARB_MODE (1)
    ) u_fx (
        .clk (clk), .rst_n (rst_n), .ch_DDR_en (ch_en), .ch_DDR_en_wr (ch_wr),
        .ch_DDR_adr (ch_adr), .ch_DDR_in (ch_in), .ch_DDR_ready (rdy_fx),
        .ch_DDR_valid (val_fx), .ch_DDR_out (out_fx), .DDR_en (en_fx),
        .DDR_en_wr (wr_fx), .DDR_adr (adr_fx), .DDR_in (in_fx), .DDR_rdy (ddr_rdy),
        .DDR_valid (ddr_valid), .DDR_out (ddr_out), .rd_outstanding (cnt_fx),
        .err_orphan (orph_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_none(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    function automatic logic [NUM_CH-1:0] oh4(input int c);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mkdata(input int v);
        logic [31:0] w;
        w = v;
        return {16{w}};
    endfunction

    // Present the oldest pending request of every channel on the upstream bus.
    task automatic drive_channels();
        logic [NUM_CH-1:0] seen;
        int c;
        seen  = '0;
        ch_en = '0;
        ch_wr = '0;
        foreach (pend_q[j]) begin
            c = pend_q[j].ch;
            if (!seen[c]) begin
                seen[c]                      = 1'b1;
                ch_en[c]                     = 1'b1;
                ch_wr[c]                     = pend_q[j].wr;
                ch_adr[c*ADDR_W +: ADDR_W]   = pend_q[j].adr;
                ch_in[c*DATA_W +: DATA_W]    = pend_q[j].data;
            end
        end
    endtask

    task automatic retire(input logic [NUM_CH-1:0] a);
        int hit;
        for (int c = 0; c < NUM_CH; c++) begin
            if (a[c]) begin
                hit = -1;
                for (int j = 0; j < pend_q.size(); j++) begin
                    if (hit < 0 && pend_q[j].ch == c) hit = j;
                end
                if (hit >= 0) pend_q.delete(hit);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) retire(acc);
            drive_channels();
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            acc = '0;
        end else begin
            mon_r = drive_fix ? rdy_fx : rdy_rr;
            acc   = mon_r;
            if (mon_r != '0) begin
                if (exp_grant_q.size() == 0) fail_none("grant_unexpected", 64'(mon_r));
                else chk("grant", 64'(mon_r), 64'(exp_grant_q.pop_front()));
            end
            mon_en  = drive_fix ? en_fx : en_rr;
            mon_act = drive_fix ? {wr_fx, adr_fx, in_fx} : {wr_rr, adr_rr, in_rr};
            if (mon_en && ddr_rdy) begin
                if (exp_req_q.size() == 0) begin
                    fail_none("req_unexpected", 64'(mon_act.adr));
                end else begin
                    mon_req = exp_req_q.pop_front();
                    chk("req_wr", 64'(mon_act.wr), 64'(mon_req.wr));
                    chk("req_adr", 64'(mon_act.adr), 64'(mon_req.adr));
                    chk_data("req_data", mon_act.data, mon_req.data);
                end
            end
            if (!drive_fix && val_rr != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    fail_none("rsp_unexpected", 64'(val_rr));
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    chk("rsp_onehot", 64'(val_rr), 64'(mon_rsp.oh));
                    chk_data("rsp_data", out_rr, mon_rsp.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int c, input logic wr, input logic [ADDR_W-1:0] adr,
                         input logic [DATA_W-1:0] data, input bit expect_grant);
        req_t r;
        r.ch = c; r.wr = wr; r.adr = adr; r.data = data;
        pend_q.push_back(r);
        if (expect_grant) begin
            exp_grant_q.push_back(oh4(c));
            exp_req_q.push_back({wr, adr, data});
        end
    endtask

    task automatic wait_grants();
        int n;
        n = 0;
        while ((exp_grant_q.size() != 0 || exp_req_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (exp_grant_q.size() != 0 || exp_req_q.size() != 0)
            fail_none("grant_timeout", 64'(exp_grant_q.size()));
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_rsp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_rsp_q.size() != 0) fail_none("rsp_timeout", 64'(exp_rsp_q.size()));
        tick();
    endtask

    task automatic send_rsp(input int c, input logic [DATA_W-1:0] d);
        exp_rsp_q.push_back({oh4(c), d});
        ddr_valid = 1'b1;
        ddr_out   = d;
        tick();
        ddr_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        ddr_valid = 1'b0;
        pend_q.delete();
        exp_grant_q.delete();
        exp_req_q.delete();
        exp_rsp_q.delete();
        drive_channels();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int ord[4];
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
        ord[0] = 0;
    end

    initial begin
        int ord[4];
        ord = '{0, 3, 0, 1};
        rst_n = 1'b0; drive_fix = 1'b0; acc = '0;
        ch_en = '0; ch_wr = '0; ch_adr = '0; ch_in = '0;
        ddr_rdy = 1'b0; ddr_valid = 1'b0; ddr_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ddr_en", 64'(en_rr), 64'(0));
        chk("rst_ready", 64'(rdy_rr), 64'(0));
        chk("rst_valid", 64'(val_rr), 64'(0));
        chk("rst_outstanding", 64'(cnt_rr), 64'(0));
        chk("rst_orphan", 64'(orph_rr), 64'(0));
        chk("rst_adr", 64'(adr_rr), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Single read from ch2
        ddr_rdy = 1'b1;
        issue(2, 1'b0, 32'h100, '0, 1'b1);
        drive_channels();
        @(negedge clk);
        chk("single_ready", 64'(rdy_rr), 64'(4'b0100));
        tick();
        @(negedge clk);
        chk("single_ddr_en", 64'(en_rr), 64'(1));
        chk("single_ddr_adr", 64'(adr_rr), 64'(32'h100));
        wait_grants();
        send_rsp(2, {64{8'hAB}});
        @(negedge clk);
        chk("single_valid", 64'(val_rr), 64'(4'b0100));
        chk_data("single_data", out_rr, {64{8'hAB}});
        wait_rsp();

        // Round-robin fairness, then in-order return to channels 0,1,2,3,0,1,2,3
        apply_reset();
        ddr_rdy = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < NUM_CH; c++)
                issue(c, 1'b0, 32'h1000 + 32'(c*16 + n), '0, 1'b1);
        drive_channels();
        wait_grants();
        chk("rr_outstanding", 64'(cnt_rr), 64'(8));
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < NUM_CH; c++)
                send_rsp(c, mkdata(32'hC0DE0000 + c*16 + n));
        wait_rsp();
        chk("rr_drained", 64'(cnt_rr), 64'(0));

        // Backpressure: ch1 write held 5 cycles, ch2 granted on release
        ddr_rdy = 1'b0;
        issue(1, 1'b1, 32'h200, mkdata(32'h1111), 1'b1);
        issue(2, 1'b1, 32'h300, mkdata(32'h2222), 1'b1);
        drive_channels();
        @(negedge clk);
        chk("bp_first_grant", 64'(rdy_rr), 64'(4'b0010));
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_en", 64'(en_rr), 64'(1));
            chk("bp_hold_adr", 64'(adr_rr), 64'(32'h200));
            chk_data("bp_hold_data", in_rr, mkdata(32'h1111));
            chk("bp_hold_ready", 64'(rdy_rr), 64'(0));
            tick();
        end
        ddr_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'(rdy_rr), 64'(4'b0100));
        wait_grants();

        // Tag limit: 9 reads from ch1, 9th stalls; a ch3 write still passes
        for (int n = 0; n < 9; n++) issue(1, 1'b0, 32'h2000 + 32'(n), '0, n < 8);
        drive_channels();
        wait_grants();
        chk("limit_outstanding", 64'(cnt_rr), 64'(8));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("limit_stall", 64'(rdy_rr), 64'(0));
            tick();
        end
        issue(3, 1'b1, 32'h3000, mkdata(32'h3333), 1'b1);
        drive_channels();
        wait_grants();
        chk("limit_after_write", 64'(cnt_rr), 64'(8));
        exp_grant_q.push_back(oh4(1));
        exp_req_q.push_back({1'b0, 32'h2008, {DATA_W{1'b0}}});
        exp_rsp_q.push_back({oh4(1), mkdata(32'h4444)});
        ddr_valid = 1'b1;
        ddr_out   = mkdata(32'h4444);
        @(negedge clk);
        chk("limit_no_grant_on_pop", 64'(rdy_rr), 64'(0));
        tick();
        ddr_valid = 1'b0;
        @(negedge clk);
        chk("limit_ninth_grant", 64'(rdy_rr), 64'(4'b0010));
        wait_grants();
        chk("limit_refilled", 64'(cnt_rr), 64'(8));
        for (int n = 0; n < 8; n++) send_rsp(1, mkdata(32'h5000 + n));
        wait_rsp();
        chk("limit_drained", 64'(cnt_rr), 64'(0));

        // In-order routing for reads issued ch0, ch3, ch0, ch1
        for (int i = 0; i < 4; i++) begin
            issue(ord[i], 1'b0, 32'h4000 + 32'(i), '0, 1'b1);
            drive_channels();
            wait_grants();
        end
        for (int i = 0; i < 4; i++) send_rsp(ord[i], mkdata(32'h6000 + i));
        wait_rsp();

        // Orphan response
        chk("orphan_clear", 64'(orph_rr), 64'(0));
        ddr_valid = 1'b1;
        ddr_out   = mkdata(32'h7777);
        tick();
        ddr_valid = 1'b0;
        @(negedge clk);
        chk("orphan_set", 64'(orph_rr), 64'(1));
        chk("orphan_no_valid", 64'(val_rr), 64'(0));
        tick();
        tick();
        @(negedge clk);
        chk("orphan_sticky", 64'(orph_rr), 64'(1));

        // Reset in the middle of a backpressured burst
        apply_reset();
        chk("orphan_reset", 64'(orph_rr), 64'(0));
        ddr_rdy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) issue(c, 1'b0, 32'h5000 + 32'(c), '0, c == 0);
        drive_channels();
        tick();
        tick();
        @(negedge clk);
        chk("midrst_pre_en", 64'(en_rr), 64'(1));
        chk("midrst_pre_cnt", 64'(cnt_rr), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 64'(en_rr), 64'(0));
        chk("midrst_ready", 64'(rdy_rr), 64'(0));
        chk("midrst_cnt", 64'(cnt_rr), 64'(0));
        chk("midrst_valid", 64'(val_rr), 64'(0));
        chk("midrst_adr", 64'(adr_rr), 64'(0));
        pend_q.delete();
        exp_grant_q.delete();
        exp_req_q.delete();
        drive_channels();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_after_cnt", 64'(cnt_rr), 64'(0));
        chk("midrst_after_en", 64'(en_rr), 64'(0));

        // Fixed priority: lowest index keeps winning while it requests
        apply_reset();
        drive_fix = 1'b1;
        ddr_rdy   = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            for (int n = 0; n < 2; n++)
                issue(c, 1'b0, 32'h6000 + 32'(c*16 + n), '0, 1'b1);
        drive_channels();
        wait_grants();
        chk("fixed_outstanding", 64'(cnt_fx), 64'(8));
        drive_fix = 1'b0;
        apply_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Parametrised N-channel DDR request arbiter and response router.
- Merges several compute engines (quan_CBR-class blocks), each with the en/en_wr/adr/in/valid/out DDR request interface, onto one downstream DDR port (MIG bridge or debug VIO).
- Tracks outstanding reads with a tag FIFO and routes in-order read data back to the issuing channel.
- Adds per-channel backpressure, round-robin or fixed-priority arbitration, and orphan-response detection.

Parameters:
- NUM_CH, 4, number of upstream channels (2..8).
- DATA_W, 512, data width.
- ADDR_W, 32, address width.
- MAX_OUTSTANDING, 8, tag FIFO depth (power of 2); maximum reads in flight.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock (150 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- ch_DDR_en  in  NUM_CH  per-channel request valid; held with payload until accepted.
- ch_DDR_en_wr  in  NUM_CH  1 = write, 0 = read.
- ch_DDR_adr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_DDR_in  in  NUM_CH*DATA_W  packed write data.
- ch_DDR_ready  out  NUM_CH  one-hot accept pulse.
- ch_DDR_valid  out  NUM_CH  one-hot read-data valid.
- ch_DDR_out  out  DATA_W  read data, broadcast to all channels.
- DDR_en  out  1  downstream request valid.
- DDR_en_wr  out  1  downstream write flag.
- DDR_adr  out  ADDR_W  downstream address.
- DDR_in  out  DATA_W  downstream write data.
- DDR_rdy  in  1  downstream accepts the request in this cycle.
- DDR_valid  in  1  downstream read data valid (in order).
- DDR_out  in  DATA_W  downstream read data.
- rd_outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag count.
- err_orphan  out  1  sticky: DDR_valid arrived with the tag FIFO empty.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0. Tag FIFO empty. Round-robin pointer 0. err_orphan 0.
- Output register (OREG): holds one request.
  - It is "free" when DDR_en=0, or when DDR_en=1 and DDR_rdy=1 in the same cycle.
- Eligibility:
  - A channel is eligible when ch_DDR_en[i]=1.
  - If it is a read, it also needs rd_outstanding < MAX_OUTSTANDING.
  - A simultaneous pop does not count toward this test.
  - A write is never blocked by the tag count.
- Grant: combinational over eligible channels, computed only when OREG is free.
  - ARB_MODE 0: search starts at rr_ptr; after a grant, rr_ptr = granted index + 1 (mod NUM_CH).
  - ARB_MODE 1: lowest eligible index wins; rr_ptr is unused.
- Accept:
  - ch_DDR_ready[g] = 1 combinationally in the grant cycle t.
  - The payload loads into OREG at the edge ending cycle t, so DDR_en = 1 from cycle t+1.
  - Request-to-DDR_en latency is 1 cycle; back-to-back grants are possible every cycle while DDR_rdy = 1.
- Hold: while DDR_en = 1 and DDR_rdy = 0, OREG is stable and no ch_DDR_ready is asserted.
- Tag push: channel id is pushed at grant time for reads only. Writes generate no tag and no response.
- Response path:
  - When DDR_valid = 1 and the FIFO is non-empty, pop the head tag.
  - Next cycle: ch_DDR_valid = onehot(tag) and ch_DDR_out = DDR_out (registered, 1-cycle latency).
  - ch_DDR_out holds its last value otherwise.
- Simultaneous push and pop: rd_outstanding unchanged, both operations performed.
- Orphan: DDR_valid with the FIFO empty drops the data, leaves ch_DDR_valid at 0, and sets err_orphan until reset.
- Reset mid-operation: in-flight OREG contents and tags are discarded.
  - Responses returning after reset are orphans; the upstream system flushes DDR before re-enabling.
- Upstream protocol violation: if ch_DDR_en drops before ready, the request is simply not granted. No error is flagged.

Decomposition:
- Package ddr_if_pkg:
  - DDR_DATA_W = 512, DDR_ADDR_W = 32.
  - ARB_RR = 0, ARB_FIXED = 1.
  - Function onehot(idx).
- Sub-module ddr_tag_fifo:
  - Synchronous FIFO, width $clog2(NUM_CH), depth MAX_OUTSTANDING.
  - Provides push/pop/count and first-word-fall-through head.
- Arbiter logic and OREG stay in the top module.

Test Plan:
- Single read: ch2 reads 0x100 with DDR_rdy = 1 -> ch_DDR_ready[2] at t, DDR_en/adr = 0x100 at t+1. DDR_valid with 0xAB.. -> ch_DDR_valid = 4'b0100 and data 0xAB.. one cycle later.
- Round-robin fairness: all 4 channels hold reads with DDR_rdy = 1 -> grants 0, 1, 2, 3, 0... with no channel granted twice within 4 cycles. With ARB_MODE = 1 the grants are 0, 0, 0...
- Backpressure: DDR_rdy = 0 for 5 cycles -> DDR_en, adr and data stable, no ch_DDR_ready. After release, the next grant follows in the same cycle.
- Tag limit: 9 reads from ch1 with no responses -> 8 accepted, rd_outstanding = 8, 9th stalled. A ch3 write is still accepted. One DDR_valid -> 9th read granted.
- In-order routing: reads issued ch0, ch3, ch0, ch1 -> 4 responses with ch_DDR_valid = 0001, 1000, 0001, 0010.
- Orphan and reset: DDR_valid with FIFO empty -> err_orphan = 1, no ch_DDR_valid. rst_n low mid-burst -> all outputs 0 within the same cycle and rd_outstanding = 0.
